// File: rtl/cp0_exc_unit.sv
// rtl/cp0_exc_unit.sv - CP0 exception/interrupt unit: Status/Cause/EPC/BadVAddr/Count/Compare
// Exceptions are resolved in the MEM stage; register updates land on the following edge.
module cp0_exc_unit #(
   parameter int          N_IRQ    = 6,
   parameter logic [31:0] EXC_VEC  = 32'hBFC0_0380,
   parameter bit          TIMER_EN = 1'b1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [N_IRQ-1:0] hw_irq,
   input  logic             mem_valid,
   input  logic [31:0]      mem_pc,
   input  logic             mem_bd,
   input  logic [7:0]       mem_exc,
   input  logic [31:0]      mem_daddr,
   input  logic             cp0_we,
   input  logic [4:0]       cp0_waddr,
   input  logic [31:0]      cp0_wdata,
   input  logic [4:0]       cp0_raddr,
   output logic [31:0]      cp0_rdata,
   output logic             flush,
   output logic [31:0]      flush_pc,
   output logic             irq_pending
);

   localparam logic [4:0] A_BADV   = 5'd8;
   localparam logic [4:0] A_COUNT  = 5'd9;
   localparam logic [4:0] A_COMP   = 5'd11;
   localparam logic [4:0] A_STATUS = 5'd12;
   localparam logic [4:0] A_CAUSE  = 5'd13;
   localparam logic [4:0] A_EPC    = 5'd14;

   localparam logic [4:0] EC_INT  = 5'd0;
   localparam logic [4:0] EC_ADEL = 5'd4;
   localparam logic [4:0] EC_ADES = 5'd5;
   localparam logic [4:0] EC_SYS  = 5'd8;
   localparam logic [4:0] EC_BP   = 5'd9;
   localparam logic [4:0] EC_RI   = 5'd10;
   localparam logic [4:0] EC_OV   = 5'd12;

   logic [N_IRQ-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
   logic             tog_q, tog_d;
   logic [31:0]      count_q, count_d;
   logic [31:0]      compare_q, compare_d;
   logic [31:0]      epc_q, epc_d;
   logic [31:0]      badv_q, badv_d;
   logic [7:0]       im_q, im_d;
   logic             exl_q, exl_d;
   logic             ie_q, ie_d;
   logic [1:0]       ipsw_q, ipsw_d;
   logic             bd_q, bd_d;
   logic             ti_q, ti_d;
   logic [4:0]       exccode_q, exccode_d;

   logic [5:0]  hw_ip;
   logic        ti_eff;
   logic [7:0]  ip;
   logic        irq_int;
   logic        take;
   logic        is_eret;
   logic [4:0]  code;
   logic        bv_ld;
   logic [31:0] bv_val;
   logic        wr_en;
   logic        count_upd;

   // Unused hardware IP lines zero-extend to read 0.
   assign hw_ip   = 6'(sync2_q);
   assign ti_eff  = TIMER_EN & ti_q;
   assign ip      = {hw_ip[5] | ti_eff, hw_ip[4:0], ipsw_q};
   assign irq_int = ie_q & ~exl_q & (|(ip & im_q));

   always_comb begin
      take    = 1'b0;
      is_eret = 1'b0;
      code    = EC_INT;
      bv_ld   = 1'b0;
      bv_val  = mem_daddr;
      if (mem_valid) begin
         take = 1'b1;
         if (irq_int)         code = EC_INT;
         else if (mem_exc[0]) begin
            code   = EC_ADEL;
            bv_ld  = 1'b1;
            bv_val = mem_pc;
         end
         else if (mem_exc[1]) code = EC_RI;
         else if (mem_exc[2]) code = EC_OV;
         else if (mem_exc[3]) code = EC_SYS;
         else if (mem_exc[4]) code = EC_BP;
         else if (mem_exc[5]) begin
            code  = EC_ADEL;
            bv_ld = 1'b1;
         end
         else if (mem_exc[6]) begin
            code  = EC_ADES;
            bv_ld = 1'b1;
         end
         else if (mem_exc[7]) is_eret = 1'b1;
         else                 take    = 1'b0;
      end
   end

   assign flush       = resetn & take;
   assign flush_pc    = is_eret ? epc_q : EXC_VEC;
   assign irq_pending = resetn & irq_int;

   // An mtc0 colliding with a taken exception or eret is dropped.
   assign wr_en = cp0_we & ~take;

   always_comb begin
      sync1_d   = hw_irq;
      sync2_d   = sync1_q;
      tog_d     = ~tog_q;
      count_d   = count_q;
      count_upd = 1'b1;
      compare_d = compare_q;
      epc_d     = epc_q;
      badv_d    = badv_q;
      im_d      = im_q;
      exl_d     = exl_q;
      ie_d      = ie_q;
      ipsw_d    = ipsw_q;
      bd_d      = bd_q;
      ti_d      = ti_q;
      exccode_d = exccode_q;

      if (wr_en && cp0_waddr == A_COUNT) count_d = cp0_wdata;
      else if (tog_q)                     count_d = count_q + 32'd1;
      else                                count_upd = 1'b0;

      if (wr_en && cp0_waddr == A_COMP) begin
         compare_d = cp0_wdata;
         ti_d      = 1'b0;
      end else if (TIMER_EN && count_upd && count_d == compare_q) begin
         ti_d = 1'b1;
      end

      if (wr_en) begin
         case (cp0_waddr)
            A_STATUS: begin
               im_d  = cp0_wdata[15:8];
               exl_d = cp0_wdata[1];
               ie_d  = cp0_wdata[0];
            end
            A_CAUSE: ipsw_d = cp0_wdata[9:8];
            A_EPC:   epc_d  = cp0_wdata;
            default: ;
         endcase
      end

      if (take) begin
         if (is_eret) begin
            exl_d = 1'b0;
         end else begin
            exccode_d = code;
            // Nested exceptions keep the original return point.
            if (!exl_q) begin
               epc_d = mem_bd ? (mem_pc - 32'd4) : mem_pc;
               bd_d  = mem_bd;
               exl_d = 1'b1;
            end
            if (bv_ld) badv_d = bv_val;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         tog_q     <= 1'b0;
         count_q   <= '0;
         compare_q <= '0;
         epc_q     <= '0;
         badv_q    <= '0;
         im_q      <= '0;
         exl_q     <= 1'b0;
         ie_q      <= 1'b0;
         ipsw_q    <= '0;
         bd_q      <= 1'b0;
         ti_q      <= 1'b0;
         exccode_q <= '0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         tog_q     <= tog_d;
         count_q   <= count_d;
         compare_q <= compare_d;
         epc_q     <= epc_d;
         badv_q    <= badv_d;
         im_q      <= im_d;
         exl_q     <= exl_d;
         ie_q      <= ie_d;
         ipsw_q    <= ipsw_d;
         bd_q      <= bd_d;
         ti_q      <= ti_d;
         exccode_q <= exccode_d;
      end
   end

   always_comb begin
      cp0_rdata = '0;
      case (cp0_raddr)
         A_BADV:   cp0_rdata = badv_q;
         A_COUNT:  cp0_rdata = count_q;
         A_COMP:   cp0_rdata = compare_q;
         A_STATUS: cp0_rdata = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
         A_CAUSE:  cp0_rdata = {bd_q, ti_eff, 14'b0, ip, 1'b0, exccode_q, 2'b0};
         A_EPC:    cp0_rdata = epc_q;
         default:  cp0_rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// tb/tb_cp0_exc_unit.sv - self-checking bench for cp0_exc_unit
// Reference model tracks architectural CP0 state and applies the exception rules per edge.
module tb_cp0_exc_unit;

   logic        clk = 1'b0;
   logic        resetn;
   logic [5:0]  hw_irq;
   logic        mem_valid;
   logic [31:0] mem_pc;
   logic        mem_bd;
   logic [7:0]  mem_exc;
   logic [31:0] mem_daddr;
   logic        cp0_we;
   logic [4:0]  cp0_waddr;
   logic [31:0] cp0_wdata;
   logic [4:0]  cp0_raddr;
   logic [31:0] cp0_rdata;
   logic        flush;
   logic [31:0] flush_pc;
   logic        irq_pending;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   cp0_exc_unit dut (
      .clk(clk), .resetn(resetn), .hw_irq(hw_irq), .mem_valid(mem_valid),
      .mem_pc(mem_pc), .mem_bd(mem_bd), .mem_exc(mem_exc), .mem_daddr(mem_daddr),
      .cp0_we(cp0_we), .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata),
      .cp0_raddr(cp0_raddr), .cp0_rdata(cp0_rdata), .flush(flush),
      .flush_pc(flush_pc), .irq_pending(irq_pending)
   );

   localparam logic [31:0] VEC = 32'hBFC0_0380;

   // Model state
   logic [7:0]  m_im;
   logic        m_exl, m_ie, m_bd, m_ti;
   logic [1:0]  m_ipsw;
   logic [4:0]  m_code;
   logic [31:0] m_epc, m_badv, m_count, m_compare;
   logic [5:0]  m_h1, m_h2;
   int          m_edges;
   int          cand_code [9] = '{0, 4, 10, 12, 8, 9, 4, 5, 0};

   logic        o_flush, o_pend, p_flush, p_pend;
   logic [31:0] o_pc, o_rdata, p_pc, p_rdata;

   function automatic void model_reset();
      m_im = 0; m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0; m_ipsw = 0; m_code = 0;
      m_epc = 0; m_badv = 0; m_count = 0; m_compare = 0; m_h1 = 0; m_h2 = 0; m_edges = 0;
   endfunction

   function automatic logic [7:0] m_ip();
      return {m_h2[5] | m_ti, m_h2[4:0], m_ipsw};
   endfunction

   function automatic logic m_pend();
      return m_ie && !m_exl && ((m_ip() & m_im) != 8'd0);
   endfunction

   // -1: nothing taken; 0: interrupt; 1..8: mem_exc bit (index-1), 8 = eret
   function automatic int m_choice();
      if (!mem_valid) return -1;
      if (m_pend()) return 0;
      for (int b = 0; b < 8; b++) if (mem_exc[b]) return b + 1;
      return -1;
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a);
      case (a)
         5'd8:  return m_badv;
         5'd9:  return m_count;
         5'd11: return m_compare;
         5'd12: return {9'b0, 1'b1, 6'b0, m_im, 6'b0, m_exl, m_ie};
         5'd13: return {m_bd, m_ti, 14'b0, m_ip(), 1'b0, m_code, 2'b0};
         5'd14: return m_epc;
         default: return 32'd0;
      endcase
   endfunction

   function automatic void model_edge();
      int   ch;
      logic wr, upd;
      ch = m_choice();
      wr = cp0_we && (ch < 0);
      m_edges++;
      upd = 1'b0;
      if (wr && cp0_waddr == 5'd9) begin m_count = cp0_wdata; upd = 1'b1; end
      else if (m_edges % 2 == 0) begin m_count = m_count + 1; upd = 1'b1; end
      if (wr && cp0_waddr == 5'd11) begin m_compare = cp0_wdata; m_ti = 1'b0; end
      else if (upd && m_count == m_compare) m_ti = 1'b1;
      if (wr && cp0_waddr == 5'd12) begin
         m_im = cp0_wdata[15:8]; m_exl = cp0_wdata[1]; m_ie = cp0_wdata[0];
      end
      if (wr && cp0_waddr == 5'd13) m_ipsw = cp0_wdata[9:8];
      if (wr && cp0_waddr == 5'd14) m_epc = cp0_wdata;
      if (ch == 8) m_exl = 1'b0;
      else if (ch >= 0) begin
         m_code = 5'(cand_code[ch]);
         if (!m_exl) begin
            m_epc = mem_bd ? mem_pc - 32'd4 : mem_pc;
            m_bd  = mem_bd;
            m_exl = 1'b1;
         end
         if (ch == 1) m_badv = mem_pc;
         if (ch == 6 || ch == 7) m_badv = mem_daddr;
      end
      m_h2 = m_h1;
      m_h1 = hw_irq;
   endfunction

   // Sample DUT and model predictions at negedge, then advance both across one edge.
   task automatic step();
      int ch;
      @(negedge clk);
      o_flush = flush; o_pc = flush_pc; o_pend = irq_pending; o_rdata = cp0_rdata;
      ch = m_choice();
      p_flush = (ch >= 0);
      p_pc    = (ch == 8) ? m_epc : VEC;
      p_pend  = m_pend();
      p_rdata = m_read(cp0_raddr);
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      mem_valid = 0; mem_exc = 0; mem_bd = 0; mem_pc = 0; mem_daddr = 0;
      cp0_we = 0; cp0_waddr = 0; cp0_wdata = 0;
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      cp0_we = 1; cp0_waddr = a; cp0_wdata = d;
      step();
      cp0_we = 0;
   endtask

   task automatic test_reset();
      logic [4:0]  addrs [6] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14};
      logic [31:0] exp;
      resetn = 0; idle(); hw_irq = 6'h3F; cp0_raddr = 0;
      mem_valid = 1; mem_exc = 8'hFF;
      repeat (3) @(posedge clk);
      #2;
      vectors++;
      if (flush !== 1'b0) begin miscompares++; $display("FAIL reset_flush got=%0b exp=0", flush); end
      vectors++;
      if (irq_pending !== 1'b0) begin miscompares++; $display("FAIL reset_pend got=%0b exp=0", irq_pending); end
      foreach (addrs[i]) begin
         cp0_raddr = addrs[i];
         #1;
         exp = (addrs[i] == 5'd12) ? 32'h0040_0000 : 32'd0;
         vectors++;
         if (cp0_rdata !== exp) begin
            miscompares++;
            $display("FAIL reset_reg%0d got=%h exp=%h", addrs[i], cp0_rdata, exp);
         end
      end
      idle(); hw_irq = 0;
      @(posedge clk); #1;
      resetn = 1;
      model_reset();
   endtask

   task automatic test_interrupt();
      int seen = 0;
      mtc0(5'd12, 32'h0040_0401);
      hw_irq = 6'h01; mem_valid = 1; mem_pc = 32'h8000_0010; mem_bd = 0; mem_exc = 0;
      cp0_raddr = 5'd13;
      for (int k = 0; k < 4; k++) begin
         step();
         vectors++;
         if (o_flush !== p_flush) begin
            miscompares++; $display("FAIL int_flush k=%0d got=%0b exp=%0b", k, o_flush, p_flush);
         end
         if (o_flush === 1'b1 && seen == 0) seen = k + 1;
      end
      vectors++;
      if (seen == 0 || seen > 3) begin miscompares++; $display("FAIL int_latency got=%0d exp=1..3", seen); end
      idle(); hw_irq = 0;
      cp0_raddr = 5'd14; step();
      vectors++;
      if (o_rdata !== 32'h8000_0010) begin miscompares++; $display("FAIL int_epc got=%h exp=80000010", o_rdata); end
      cp0_raddr = 5'd13; step();
      vectors++;
      if (o_rdata[6:2] !== 5'd0) begin miscompares++; $display("FAIL int_code got=%0d exp=0", o_rdata[6:2]); end
      cp0_raddr = 5'd12; step();
      vectors++;
      if (o_rdata[1] !== 1'b1) begin miscompares++; $display("FAIL int_exl got=%0b exp=1", o_rdata[1]); end
   endtask

   task automatic test_delay_slot();
      idle(); mtc0(5'd12, 32'h0040_0000);
      mem_valid = 1; mem_exc = 8'h04; mem_pc = 32'h8000_0104; mem_bd = 1;
      step();
      vectors++;
      if (o_flush !== 1'b1 || o_pc !== VEC) begin
         miscompares++; $display("FAIL ds_flush got=%0b/%h exp=1/%h", o_flush, o_pc, VEC);
      end
      idle(); cp0_raddr = 5'd14; step();
      vectors++;
      if (o_rdata !== 32'h8000_0100) begin miscompares++; $display("FAIL ds_epc got=%h exp=80000100", o_rdata); end
      cp0_raddr = 5'd13; step();
      vectors++;
      if (o_rdata[31] !== 1'b1 || o_rdata[6:2] !== 5'd12) begin
         miscompares++; $display("FAIL ds_cause got=%h exp BD=1 code=12", o_rdata);
      end
   endtask

   task automatic test_priority();
      idle(); mtc0(5'd12, 32'h0);
      mem_valid = 1; mem_exc = 8'b0110_0001; mem_pc = 32'h8000_0203; mem_daddr = $urandom;
      step();
      vectors++;
      if (o_flush !== 1'b1) begin miscompares++; $display("FAIL prio_flush got=%0b exp=1", o_flush); end
      idle(); cp0_raddr = 5'd8; step();
      vectors++;
      if (o_rdata !== 32'h8000_0203) begin miscompares++; $display("FAIL prio_badv got=%h exp=80000203", o_rdata); end
      cp0_raddr = 5'd13; step();
      vectors++;
      if (o_rdata[6:2] !== 5'd4) begin miscompares++; $display("FAIL prio_code got=%0d exp=4", o_rdata[6:2]); end
   endtask

   task automatic test_timer();
      int first = -1;
      idle();
      mtc0(5'd11, 32'd5);
      mtc0(5'd9, 32'd0);
      cp0_raddr = 5'd13;
      for (int k = 1; k <= 13; k++) begin
         step();
         vectors++;
         if (o_rdata !== p_rdata) begin
            miscompares++; $display("FAIL timer_cause k=%0d got=%h exp=%h", k, o_rdata, p_rdata);
         end
         if (o_rdata[30] === 1'b1 && first < 0) first = k - 1;
      end
      vectors++;
      if (first < 9 || first > 10) begin miscompares++; $display("FAIL timer_ti_edges got=%0d exp=9..10", first); end
      mtc0(5'd11, 32'h0001_0000);
      step();
      vectors++;
      if (o_rdata[30] !== 1'b0) begin miscompares++; $display("FAIL timer_ti_clear got=%0b exp=0", o_rdata[30]); end
      mtc0(5'd9, 32'hFFFF_FFFF);
      cp0_raddr = 5'd9;
      repeat (3) step();
      vectors++;
      if (o_rdata !== 32'd0) begin miscompares++; $display("FAIL timer_wrap got=%h exp=00000000", o_rdata); end
   endtask

   task automatic test_eret();
      idle();
      mtc0(5'd14, 32'h8000_0040);
      mtc0(5'd12, 32'h0040_0002);
      mem_valid = 1; mem_exc = 8'h80;
      cp0_we = 1; cp0_waddr = 5'd12; cp0_wdata = 32'h0040_0401;
      step();
      vectors++;
      if (o_flush !== 1'b1 || o_pc !== 32'h8000_0040) begin
         miscompares++; $display("FAIL eret_flush got=%0b/%h exp=1/80000040", o_flush, o_pc);
      end
      idle(); cp0_raddr = 5'd12; step();
      vectors++;
      if (o_rdata !== 32'h0040_0000) begin miscompares++; $display("FAIL eret_status got=%h exp=00400000", o_rdata); end
   endtask

   task automatic test_irq_preempts_eret();
      idle();
      mtc0(5'd14, 32'h8000_0040);
      mtc0(5'd13, 32'h0000_0100);
      mtc0(5'd12, 32'h0040_0101);
      cp0_raddr = 5'd12; step();
      vectors++;
      if (o_pend !== 1'b1) begin miscompares++; $display("FAIL pre_pend got=%0b exp=1", o_pend); end
      mem_valid = 1; mem_exc = 8'h80; mem_pc = 32'h8000_0300;
      step();
      vectors++;
      if (o_flush !== 1'b1 || o_pc !== VEC) begin
         miscompares++; $display("FAIL pre_flush got=%0b/%h exp=1/%h", o_flush, o_pc, VEC);
      end
      idle(); mtc0(5'd13, 32'h0);
      cp0_raddr = 5'd13; step();
      vectors++;
      if (o_rdata[6:2] !== 5'd0) begin miscompares++; $display("FAIL pre_code got=%0d exp=0", o_rdata[6:2]); end
   endtask

   task automatic test_reset_midop();
      idle(); mtc0(5'd12, 32'h0);
      mem_valid = 1; mem_exc = 8'h04; mem_pc = 32'h8000_0500;
      @(negedge clk);
      resetn = 0;
      #1;
      vectors++;
      if (flush !== 1'b0) begin miscompares++; $display("FAIL rst_mid_flush got=%0b exp=0", flush); end
      @(posedge clk); #1;
      cp0_raddr = 5'd14; #1;
      vectors++;
      if (cp0_rdata !== 32'd0) begin miscompares++; $display("FAIL rst_mid_epc got=%h exp=0", cp0_rdata); end
      cp0_raddr = 5'd12; #1;
      vectors++;
      if (cp0_rdata !== 32'h0040_0000) begin miscompares++; $display("FAIL rst_mid_status got=%h exp=00400000", cp0_rdata); end
      idle();
      @(posedge clk); #1;
      resetn = 1;
      model_reset();
   endtask

   task automatic test_random();
      logic [4:0] addrs [8] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd31};
      for (int c = 0; c < 400; c++) begin
         mem_valid = ($urandom % 2) == 0;
         mem_exc   = ($urandom % 3 == 0) ? 8'($urandom) : 8'd0;
         mem_pc    = $urandom;
         mem_daddr = $urandom;
         mem_bd    = $urandom % 2 == 0;
         if ($urandom % 8 == 0) hw_irq = 6'($urandom);
         cp0_we    = ($urandom % 3 == 0);
         cp0_waddr = addrs[$urandom % 8];
         cp0_wdata = $urandom;
         cp0_raddr = addrs[$urandom % 8];
         step();
         vectors++;
         if (o_flush !== p_flush) begin
            miscompares++; $display("FAIL rand_flush c=%0d got=%0b exp=%0b", c, o_flush, p_flush);
         end
         vectors++;
         if (p_flush && o_pc !== p_pc) begin
            miscompares++; $display("FAIL rand_pc c=%0d got=%h exp=%h", c, o_pc, p_pc);
         end
         vectors++;
         if (o_pend !== p_pend) begin
            miscompares++; $display("FAIL rand_pend c=%0d got=%0b exp=%0b", c, o_pend, p_pend);
         end
         vectors++;
         if (o_rdata !== p_rdata) begin
            miscompares++; $display("FAIL rand_rdata c=%0d a=%0d got=%h exp=%h", c, cp0_raddr, o_rdata, p_rdata);
         end
      end
      idle(); hw_irq = 0;
   endtask

   initial begin
      resetn = 0; hw_irq = 0; cp0_raddr = 0;
      idle();
      model_reset();
      test_reset();
      test_interrupt();
      test_delay_slot();
      test_priority();
      test_timer();
      test_eret();
      test_irq_preempts_eret();
      test_reset_midop();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/cp0_exc_unit.md
CP0_EXC_UNIT -- requirements
Module: cp0_exc_unit

Interface
REQ-001 Parameter N_IRQ, default 6: number of hardware interrupt lines, legal range 1..6.
REQ-002 Parameter EXC_VEC, default 32'hBFC0_0380: flush_pc on any exception.
REQ-003 Parameter TIMER_EN, default 1: 1 enables the Count/Compare timer interrupt on IP7.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 hw_irq  in  N_IRQ  asynchronous level interrupt requests, mapped to IP[2+i].
REQ-007 mem_valid  in  1  the MEM-stage instruction is valid this cycle.
REQ-008 mem_pc  in  32  address of the MEM-stage instruction itself, not PC+4.
REQ-009 mem_bd  in  1  the MEM-stage instruction sits in a branch delay slot.
REQ-010 mem_exc  in  8  bit [0]=AdEL fetch, [1]=RI, [2]=Ov, [3]=Sys, [4]=Bp, [5]=AdEL data, [6]=AdES, [7]=eret.
REQ-011 mem_daddr  in  32  data address of the MEM-stage load or store.
REQ-012 cp0_we / cp0_waddr / cp0_wdata  in  1/5/32  mtc0 write port.
REQ-013 cp0_raddr  in  5  mfc0 read address; cp0_rdata  out  32  combinational read data.
REQ-014 flush  out  1  combinational; asserted when an exception or eret is taken this cycle.
REQ-015 flush_pc  out  32  redirect target, valid while flush=1.
REQ-016 irq_pending  out  1  combinational interrupt-ready indication for the pipeline.

Function
REQ-017 Registers: BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14); all other addresses read 0 and ignore writes.
REQ-018 Writable Status fields: IM[15:8], EXL[1], IE[0]; BEV[22] reads 1; all other Status bits read 0.
REQ-019 Writable Cause field: IP[1:0] only; BadVAddr is read-only; EPC, Count and Compare are fully writable.
REQ-020 hw_irq passes through a 2-flop synchroniser; IP[2+i] equals the synchronised hw_irq[i], so a rising hw_irq is visible in Cause 2 edges later; unused IP bits read 0.
REQ-021 Count increments by 1 on every second clk edge using a toggle flop; Count wraps 32'hFFFF_FFFF to 0.
REQ-022 An mtc0 write to Count takes priority over that cycle's increment.
REQ-023 When TIMER_EN=1 and Count==Compare after an update, Cause.TI[30] sets and stays set.
REQ-024 Cause.TI clears only on an mtc0 write to Compare, which wins over a same-cycle compare match.
REQ-025 IP7 = synchronised hw_irq[5] OR TI.
REQ-026 irq_pending = IE & ~EXL & |(IP & IM).
REQ-027 An exception is taken only when mem_valid=1; candidate priority: interrupt > AdEL fetch > RI > Ov > Sys > Bp > AdEL data > AdES > eret.
REQ-028 ExcCodes: Int=0, AdEL=4, AdES=5, Sys=8, Bp=9, RI=10, Ov=12.
REQ-029 Taken exception, same cycle: flush=1, flush_pc=EXC_VEC.
REQ-030 Taken exception, next edge when EXL was 0: EPC = mem_bd ? mem_pc-4 : mem_pc; Cause.BD = mem_bd; EXL set.
REQ-031 Taken exception, next edge when EXL was 1: EPC and BD unchanged; ExcCode still updated.
REQ-032 Taken exception, next edge in all cases: Cause.ExcCode set per REQ-028.
REQ-033 BadVAddr updates only on AdEL fetch (loads mem_pc) and on AdEL data or AdES (loads mem_daddr).
REQ-034 eret taken: flush=1, flush_pc=EPC (the current register value); EXL clears at the next edge.
REQ-035 A pending interrupt pre-empts an eret in the same cycle.
REQ-036 A cp0_we in the same cycle as a taken exception or eret is discarded.
REQ-037 An mtc0 to Status or EPC becomes visible on cp0_rdata the cycle after the write.
REQ-038 Address arithmetic is modulo 2^32.

Reset
REQ-039 On resetn=0, asynchronously: Status=32'h0040_0000; Cause, EPC, BadVAddr, Count, Compare, toggle flop and synchronisers = 0.
REQ-040 During reset, flush=0 and irq_pending=0; reset asserted mid-operation abandons any in-flight update.

Verification
REQ-041 Interrupt path: Status=32'h0040_0401, pulse hw_irq[0] held high, mem_valid=1, mem_pc=32'h8000_0010, mem_bd=0 -> within 3 cycles flush=1, flush_pc=32'hBFC0_0380; then EPC=32'h8000_0010, ExcCode=0, EXL=1.
REQ-042 Delay slot: mem_exc[2]=1, mem_pc=32'h8000_0104, mem_bd=1 -> EPC=32'h8000_0100, Cause.BD=1, ExcCode=12.
REQ-043 Priority and address: mem_exc=8'b0110_0001, mem_pc=32'h8000_0203 -> ExcCode=4, BadVAddr=32'h8000_0203; mem_daddr is ignored.
REQ-044 Timer: Compare=5, Count=0 -> TI=1 after 10 edges; an mtc0 to Compare clears TI; when Count=32'hFFFF_FFFF, 2 edges later Count=0.
REQ-045 eret with an mtc0 in the same cycle: EPC=32'h8000_0040, EXL=1, mem_exc[7]=1 with cp0_we to Status -> flush_pc=32'h8000_0040, EXL=0 next edge, Status write dropped.
